// File: rtl/shift_sipo_rx.sv
// Serial-in/parallel-out receiver: reassembles WIDTH-bit words from an MSB- or LSB-first
// bit stream and presents them on a held valid/ready output with a sticky overrun flag.
module shift_sipo_rx #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    input  logic             clr_ovr
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             accept;

    // Direction is the latched one: msb_first only matters on the start bit.
    always_comb begin
        shifted = dir_q ? {sreg_q[WIDTH-2:0], sin} : {sin, sreg_q[WIDTH-1:1]};
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        complete = 1'b0;

        if (sin_valid && start) begin
            // A start bit always opens a fresh frame, discarding any partial word.
            dir_d   = msb_first;
            sreg_d  = msb_first ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
            cnt_d   = CW'(1);
            state_d = RECV;
        end else if (sin_valid && state_q == RECV) begin
            sreg_d = shifted;
            if (cnt_q == LAST_IDX) begin
                complete = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output register: a completing word loads unless the held word is still unaccepted.
    always_comb begin
        accept = vld_q && dout_ready;
        dout_d = dout_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;

        if (complete) begin
            if (!vld_q || dout_ready) begin
                dout_d = shifted;
                vld_d  = 1'b1;
            end
        end else if (accept) begin
            vld_d = 1'b0;
        end

        if (complete && vld_q && !dout_ready) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            // NOTE: the shift register is reset too, so a reset mid-frame leaves no stale bits behind.
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign busy       = (state_q == RECV);
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_shift_sipo_rx.sv
// Scoreboard bench for shift_sipo_rx: a word-level model predicts deliveries and overrun,
// a negedge monitor compares DUT outputs against it.
module tb_shift_sipo_rx;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             start = 1'b0;
    logic             msb_first = 1'b1;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             clr_ovr = 1'b0;

    shift_sipo_rx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .start      (start),
        .msb_first  (msb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Word-level reference model: the word being sent, bits seen in the frame,
    // whether the output register is occupied, and the sticky overrun flag.
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] cur_word;
    int               f_cnt = 0;
    logic             m_full = 1'b0;
    logic             m_ovr = 1'b0;
    bit               rand_rdy = 1'b0;
    bit               rand_clr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applied right after each edge using the inputs that were present at it.
    task automatic model_update();
        bit done;
        bit ovr_ev;
        done   = 1'b0;
        ovr_ev = 1'b0;
        if (!rst_n) begin
            f_cnt  = 0;
            m_full = 1'b0;
            m_ovr  = 1'b0;
            sb.delete();
            return;
        end
        if (sin_valid) begin
            if (start) begin
                f_cnt = 1;
            end else if (f_cnt != 0) begin
                f_cnt++;
                if (f_cnt == WIDTH) begin
                    done  = 1'b1;
                    f_cnt = 0;
                end
            end
        end
        if (done) begin
            if (!m_full || dout_ready) begin
                sb.push_back(cur_word);
                m_full = 1'b1;
            end else begin
                ovr_ev = 1'b1;
            end
        end else if (m_full && dout_ready) begin
            m_full = 1'b0;
        end
        if (ovr_ev) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
    endtask

    task automatic step();
        if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
        if (rand_clr) clr_ovr = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        sin_valid = 1'b0;
        start     = 1'b0;
        sin       = 1'($urandom_range(0, 1));
        msb_first = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic send_bit(input logic b, input logic st, input logic d);
        sin_valid = 1'b1;
        sin       = b;
        start     = st;
        msb_first = d;
        step();
        sin_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Sends the first nbits of w; msb_first is randomised after the start bit to show it is ignored.
    task automatic send_frame(input logic [WIDTH-1:0] w, input logic dir, input int nbits,
                              input int maxgap, input int gap_at);
        cur_word = w;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                int g;
                g = (i == gap_at) ? 3 : int'($urandom_range(0, maxgap));
                for (int k = 0; k < g; k++) idle();
            end
            send_bit(dir ? w[WIDTH-1-i] : w[i], i == 0,
                     (i == 0) ? dir : 1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: compares handshake state every cycle and pops the scoreboard on each transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("dout_valid", 32'(dout_valid), 32'(m_full));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("bit_cnt", 32'(bit_cnt), 32'(f_cnt));
            check("busy", 32'(busy), 32'(f_cnt != 0));
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got word %0h expected none at %0t", dout, $time);
                end else begin
                    logic [WIDTH-1:0] exp_w;
                    exp_w = sb.pop_front();
                    check("dout_xfer", 32'(dout), 32'(exp_w));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        step();
        rst_n = 1'b1;
        idle();

        // Reset mid-frame after 5 bits.
        dout_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 5, 0, -1);
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bit_cnt", 32'(bit_cnt), 0);
        check("rst_overrun", 32'(overrun), 0);

        // MSB-first, consecutive bits: valid one cycle after the 8th bit, for one cycle.
        send_frame(8'hA5, 1'b1, WIDTH, 0, -1);
        check("msb_dout", 32'(dout), 32'hA5);
        check("msb_valid", 32'(dout_valid), 1);
        idle();
        check("msb_valid_pulse", 32'(dout_valid), 0);

        // LSB-first with a 3-cycle gap before bit 5.
        send_frame(8'h04, 1'b0, WIDTH, 0, 4);
        check("lsb_dout", 32'(dout), 32'h04);
        idle();

        // Back-to-back frames under backpressure.
        dout_ready = 1'b0;
        send_frame(8'h3C, 1'b1, WIDTH, 0, -1);
        send_frame(8'hC3, 1'b1, WIDTH, 0, -1);
        check("bp_dout", 32'(dout), 32'h3C);
        check("bp_overrun", 32'(overrun), 1);
        dout_ready = 1'b1;
        idle();
        check("bp_valid_fall", 32'(dout_valid), 0);
        clr_ovr = 1'b1;
        idle();
        clr_ovr = 1'b0;
        check("bp_clr_ovr", 32'(overrun), 0);

        // Restart after 5 bits, then a full frame.
        send_frame(8'hFF, 1'b1, 5, 0, -1);
        send_frame(8'h81, 1'b1, WIDTH, 0, -1);
        check("restart_dout", 32'(dout), 32'h81);
        idle();
        check("restart_single", 32'(dout_valid), 0);

        // Simultaneous accept of 8'h11 and completion of 8'h22.
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b1, WIDTH, 0, -1);
        send_frame(8'h22, 1'b1, WIDTH - 1, 0, -1);
        dout_ready = 1'b1;
        send_bit(cur_word[0], 1'b0, 1'b0);
        check("simul_dout", 32'(dout), 32'h22);
        check("simul_valid", 32'(dout_valid), 1);
        check("simul_overrun", 32'(overrun), 0);
        idle();

        // Randomised frames, partial frames, gaps, backpressure and overrun clears.
        rand_rdy = 1'b1;
        rand_clr = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int nb;
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, WIDTH - 1)) : WIDTH;
            send_frame(WIDTH'($urandom), 1'($urandom_range(0, 1)), nb, 2, -1);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle();
        end
        rand_rdy   = 1'b0;
        rand_clr   = 1'b0;
        dout_ready = 1'b1;
        clr_ovr    = 1'b1;
        idle();
        clr_ovr = 1'b0;
        for (int k = 0; k < 3; k++) idle();
        check("sb_leftover", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sipo_rx.md
Name: shift_sipo_rx

Overview:
Serial-in/parallel-out receiver. It reassembles a WIDTH-bit word from a bit stream that the companion parallel shifter emits one bit per sample, either MSB-first (left shift) or LSB-first (right shift). Completed words go to a held output register with a valid/ready handshake. A sticky overrun flag is set when a word completes while the previous word is still unaccepted. It sits between the serial link and the byte-wide datapath.

Parameters:
WIDTH, 8, word length in bits (legal range 2..32).
CW, $clog2(WIDTH+1), width of the bit counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on this cycle.
start  input  1  frame sync; qualified only when sin_valid=1; marks the current bit as the first bit of a word.
msb_first  input  1  1 = MSB-first (shift left, new bit enters bit 0); 0 = LSB-first (shift right, new bit enters bit WIDTH-1). Latched at start.
dout  output  WIDTH  received word.
dout_valid  output  1  dout holds an unaccepted word.
dout_ready  input  1  consumer accepts dout when dout_valid=1.
busy  output  1  frame in progress (state RECV).
bit_cnt  output  CW  bits captured in the current frame.
overrun  output  1  sticky: a completed word was dropped.
clr_ovr  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; shift register=0; dout=0; dout_valid=0; busy=0; bit_cnt=0; overrun=0; latched direction=1. Reset mid-frame discards the partial word and any pending dout.
- States:
  - IDLE: sin_valid=1 and start=1 -> latch msb_first, capture sin as bit 1 of the frame, bit_cnt=1, go to RECV. sin_valid=1 with start=0 -> ignored, no change.
  - RECV: each sin_valid=1 cycle shifts one bit in and increments bit_cnt. sin_valid=0 -> hold everything; gaps of any length are allowed.
- Shift rules:
  - MSB-first: sreg <= {sreg[WIDTH-2:0], sin}.
  - LSB-first: sreg <= {sin, sreg[WIDTH-1:1]}.
  - After WIDTH bits, sreg equals the transmitted word in either mode.
- Completion: on the edge capturing bit WIDTH:
  - the full word (including that bit) is written to dout;
  - dout_valid=1 from the next cycle;
  - bit_cnt=0 and state=IDLE;
  - latency from last bit sampled to dout_valid high is 1 clock.
- Back-to-back frames: start=1 on the cycle right after completion is accepted; there is no dead cycle.
- start=1 while in RECV: the partial word is discarded silently. The current bit becomes bit 1 of a new frame, msb_first is re-latched, and bit_cnt=1.
- Handshake:
  - Transfer occurs on an edge with dout_valid=1 and dout_ready=1. dout_valid then falls unless a new word completes on the same edge. In that case the new word loads and dout_valid stays 1.
  - dout stays stable while dout_valid=1 and dout_ready=0.
- Overrun: a word completes while dout_valid=1 and dout_ready=0 -> the new word is dropped, dout is unchanged, and overrun=1 from the next cycle. overrun stays set until clr_ovr=1 or reset. If clr_ovr and a new overrun event occur on the same edge, the set wins.
- start=1 with WIDTH=… boundary: a frame never exceeds WIDTH bits; bit_cnt never reaches WIDTH as a held value.
- busy = (state==RECV). bit_cnt is combinationally visible and equals the number of bits captured so far.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-frame after 5 bits, then rst_n=1 -> dout=8'h00, dout_valid=0, busy=0, bit_cnt=0, overrun=0. A subsequent clean frame 8'hA5 is received correctly.
- MSB-first: msb_first=1, start on the first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=1 -> dout=8'hA5, with dout_valid high for exactly 1 cycle, 1 clock after the 8th bit.
- LSB-first with gaps: msb_first=0, send 8'h04 LSB-first (0,0,1,0,0,0,0,0) with sin_valid=0 for 3 cycles between bits 4 and 5 -> dout=8'h04. Toggling msb_first mid-frame has no effect.
- Back-to-back and backpressure: frames 8'h3C then 8'hC3 with no gap, dout_ready=0 -> dout holds 8'h3C, overrun=1 after the second frame completes. Then dout_ready=1 -> dout_valid falls. Then clr_ovr=1 -> overrun=0.
- Restart: start=1 after 5 bits of 8'hFF, then a full frame 8'h81 -> only 8'h81 is delivered, with one dout_valid pulse.
- Simultaneous accept and complete: dout_valid=1 holding 8'h11 while the last bit of 8'h22 arrives with dout_ready=1 on the same edge -> dout=8'h22, dout_valid stays 1, overrun=0.
